// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side stream stage.
package fifo_pkg;

  localparam int unsigned DSIZE_DEF   = 8;
  localparam int unsigned PKT_LEN_DEF = 4;
  localparam int unsigned PKT_CNT_W   = 16;

  // One skid-buffer slot: payload word plus its end-of-packet marker.
  typedef struct packed {
    logic                 last;
    logic [DSIZE_DEF-1:0] data;
  } skid_entry_t;

  // Beat counter width: ceil(log2(len)), never narrower than one bit.
  function automatic int unsigned beat_width(input int unsigned len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Generic 2-entry registered FIFO-style skid buffer, head at entry 0.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter type T = skid_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  T           push_data,
  input  logic       pop,
  output T           head,
  output logic [1:0] occ
);

  T           r_mem0;
  T           r_mem1;
  logic [1:0] r_occ;
  T           w_mem0_nxt;
  T           w_mem1_nxt;
  logic [1:0] w_occ_nxt;
  logic       w_push_ok;
  logic       w_pop_ok;

  // A push into a full buffer is only honoured when a pop frees a slot.
  assign w_push_ok = push & ((r_occ != 2'd2) | w_pop_ok);
  assign w_pop_ok  = pop & (r_occ != 2'd0);

  // Next-state: shift on pop, write the new word into the tail slot.
  always_comb begin
    w_mem0_nxt = r_mem0;
    w_mem1_nxt = r_mem1;
    w_occ_nxt  = r_occ;
    if (flush) begin
      w_occ_nxt = 2'd0;
    end else begin
      if (w_pop_ok) begin
        w_mem0_nxt = r_mem1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10: begin
          w_occ_nxt = r_occ + 2'd1;
          if (r_occ == 2'd0) w_mem0_nxt = push_data;
          else               w_mem1_nxt = push_data;
        end
        2'b11: begin
          if (r_occ == 2'd1) w_mem0_nxt = push_data;
          else               w_mem1_nxt = push_data;
        end
        2'b01: begin
          w_occ_nxt = r_occ - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem0 <= '0;
      r_mem1 <= '0;
      r_occ  <= 2'd0;
    end else begin
      r_mem0 <= w_mem0_nxt;
      r_mem1 <= w_mem1_nxt;
      r_occ  <= w_occ_nxt;
    end
  end

  assign head = r_mem0;
  assign occ  = r_occ;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the FIFO read port into a packetised valid/ready stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE   = DSIZE_DEF,
  parameter int unsigned PKT_LEN = PKT_LEN_DEF
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 enable,
  input  logic                 flush,
  input  logic [DSIZE-1:0]     fifo_rdata,
  input  logic                 fifo_rempty,
  output logic                 fifo_rinc,
  output logic [DSIZE-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic [PKT_CNT_W-1:0] pkt_count
);

  localparam int unsigned       BEAT_W    = beat_width(PKT_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  typedef struct packed {
    logic             last;
    logic [DSIZE-1:0] data;
  } entry_t;

  logic [BEAT_W-1:0]    r_beat;
  logic [PKT_CNT_W-1:0] r_pkt_count;
  logic [1:0]           w_occ;
  entry_t               w_push_entry;
  entry_t               w_head;
  logic                 w_is_last;
  logic                 w_accept;

  // Pop only from registered occupancy, so m_ready never reaches fifo_rinc.
  assign fifo_rinc    = rrst_n & enable & ~flush & ~fifo_rempty & (w_occ != 2'd2);
  assign w_is_last    = (r_beat == LAST_BEAT);
  assign w_push_entry = {w_is_last, fifo_rdata};
  assign w_accept     = m_valid & m_ready;

  skid_buf2 #(
    .T(entry_t)
  ) u_skid (
    .clk      (rclk),
    .rst_n    (rrst_n),
    .flush    (flush),
    .push     (fifo_rinc),
    .push_data(w_push_entry),
    .pop      (w_accept),
    .head     (w_head),
    .occ      (w_occ)
  );

  assign m_valid   = (w_occ != 2'd0);
  assign m_data    = w_head.data;
  assign m_last    = w_head.last;
  assign pkt_count = r_pkt_count;

  // Packet framing: beat index of the next word pushed into the buffer.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_beat <= '0;
    end else if (flush) begin
      r_beat <= '0;
    end else if (fifo_rinc) begin
      r_beat <= w_is_last ? '0 : r_beat + BEAT_W'(1);
    end
  end

  // Completed-packet counter; survives flush, wraps naturally.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_pkt_count <= '0;
    end else if (w_accept && m_last) begin
      r_pkt_count <= r_pkt_count + PKT_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO read port.
module tb_fifo_rd_stream;

  logic        rclk;
  logic        rrst_n;
  logic        enable;
  logic        flush;
  logic [7:0]  fifo_rdata;
  logic        fifo_rempty;
  logic        fifo_rinc;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [15:0] pkt_count;

  int checks;
  int failures;

  // Behavioural FIFO: written by the stimulus, popped by fifo_rinc.
  logic [7:0] mem [0:63];
  logic [5:0] wr_ptr;
  logic [5:0] rd_ptr;
  int         cyc;

  logic [7:0] rx_d [$];
  logic       rx_l [$];
  int         rx_c [$];

  fifo_rd_stream #(.DSIZE(8), .PKT_LEN(4)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .enable     (enable),
    .flush      (flush),
    .fifo_rdata (fifo_rdata),
    .fifo_rempty(fifo_rempty),
    .fifo_rinc  (fifo_rinc),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .pkt_count  (pkt_count)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  assign fifo_rempty = (rd_ptr == wr_ptr);
  assign fifo_rdata  = mem[rd_ptr];

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) rd_ptr <= '0;
    else if (fifo_rinc) rd_ptr <= rd_ptr + 6'd1;
  end

  always @(posedge rclk) cyc <= cyc + 1;

  // Record every handshake, sampled mid-cycle.
  always @(negedge rclk) begin
    if (rrst_n && m_valid && m_ready) begin
      rx_d.push_back(m_data);
      rx_l.push_back(m_last);
      rx_c.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic fifo_write(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_d.size() < n && k < budget) begin
      step(1);
      k++;
    end
    step(1);
    check("rx_count", 32'(rx_d.size()), 32'(n));
  endtask

  task automatic check_burst(input string tag, input int base, input int stride);
    for (int i = 0; i < 8; i++) begin
      if (i < rx_d.size()) begin
        check({tag, "_data"}, 32'(rx_d[i]), 32'(base + stride * i));
        check({tag, "_last"}, 32'(rx_l[i]), 32'((i % 4) == 3));
      end
    end
  endtask

  task automatic rx_clear();
    rx_d.delete();
    rx_l.delete();
    rx_c.delete();
  endtask

  initial begin
    logic [5:0] base;
    int         hits;
    logic       rdy;
    int         k;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    wr_ptr   = '0;
    rrst_n   = 1'b0;
    enable   = 1'b1;
    flush    = 1'b0;
    m_ready  = 1'b0;
    #12;
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_pkt", 32'(pkt_count), 32'd0);
    check("rst_rinc", 32'(fifo_rinc), 32'd0);
    @(negedge rclk);
    rrst_n = 1'b1;
    step(1);

    // Streaming with m_ready held high.
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) fifo_write(8'(5 * i));
    wait_rx(8, 30);
    check_burst("stream", 5, 5);
    if (rx_c.size() == 8) check("stream_gapless", 32'(rx_c[7] - rx_c[0]), 32'd7);
    check("stream_pkt", 32'(pkt_count), 32'd2);
    rx_clear();

    // Backpressure: only two words leave the FIFO.
    m_ready = 1'b0;
    base = rd_ptr;
    for (int i = 1; i <= 8; i++) fifo_write(8'(5 * i));
    step(10);
    check("bp_pops", 32'(6'(rd_ptr - base)), 32'd2);
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_data", 32'(m_data), 32'd5);
    check("bp_rinc", 32'(fifo_rinc), 32'd0);
    m_ready = 1'b1;
    wait_rx(8, 30);
    check_burst("bp", 5, 5);
    check("bp_pkt", 32'(pkt_count), 32'd4);
    rx_clear();

    // m_ready toggling every cycle.
    for (int i = 1; i <= 8; i++) fifo_write(8'(5 * i));
    rdy = 1'b1;
    k = 0;
    while (rx_d.size() < 8 && k < 60) begin
      m_ready = rdy;
      rdy = ~rdy;
      step(1);
      k++;
    end
    m_ready = 1'b0;
    step(1);
    check("tog_count", 32'(rx_d.size()), 32'd8);
    check_burst("tog", 5, 5);
    check("tog_pkt", 32'(pkt_count), 32'd6);
    rx_clear();

    // Flush with the third word buffered after two accepted.
    fifo_write(8'd200);
    fifo_write(8'd201);
    fifo_write(8'd202);
    step(4);
    m_ready = 1'b1;
    step(2);
    m_ready = 1'b0;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("fl_valid", 32'(m_valid), 32'd0);
    check("fl_pkt", 32'(pkt_count), 32'd6);
    check("fl_acc", 32'(rx_d.size()), 32'd2);
    if (rx_d.size() == 2) check("fl_acc1", 32'(rx_d[1]), 32'd201);
    rx_clear();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) fifo_write(8'(100 + i));
    wait_rx(4, 30);
    for (int i = 0; i < rx_d.size() && i < 4; i++) begin
      check("fl_data", 32'(rx_d[i]), 32'(100 + i));
      check("fl_last", 32'(rx_l[i]), 32'(i == 3));
    end
    check("fl_pkt2", 32'(pkt_count), 32'd7);
    rx_clear();

    // Enable low: drain continues, no pops, framing held.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_write(8'(50 + i));
    step(3);
    enable  = 1'b0;
    m_ready = 1'b1;
    base = rd_ptr;
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      if (fifo_rinc) hits++;
      step(1);
    end
    check("en_rinc", 32'(hits), 32'd0);
    check("en_ptr", 32'(rd_ptr), 32'(base));
    check("en_drain", 32'(rx_d.size()), 32'd2);
    check("en_valid", 32'(m_valid), 32'd0);
    enable = 1'b1;
    wait_rx(4, 30);
    for (int i = 0; i < rx_d.size() && i < 4; i++) begin
      check("en_data", 32'(rx_d[i]), 32'(50 + i));
      check("en_last", 32'(rx_l[i]), 32'(i == 3));
    end
    check("en_pkt", 32'(pkt_count), 32'd8);
    rx_clear();

    // Reset mid-packet with the buffer full.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_write(8'(60 + i));
    step(3);
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    #2;
    rrst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_pkt", 32'(pkt_count), 32'd0);
    check("mid_rst_data", 32'(m_data), 32'd0);
    check("mid_rst_rinc", 32'(fifo_rinc), 32'd0);
    wr_ptr = '0;
    rx_clear();
    @(negedge rclk);
    rrst_n = 1'b1;
    step(1);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) fifo_write(8'(70 + i));
    wait_rx(4, 30);
    for (int i = 0; i < rx_d.size() && i < 4; i++) begin
      check("rs_data", 32'(rx_d[i]), 32'(70 + i));
      check("rs_last", 32'(rx_l[i]), 32'(i == 3));
    end
    check("rs_pkt", 32'(pkt_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
